// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner for common-cathode digits.
// A free-running divider sets the slot period. Each slot change blanks all commons
// for DEAD_CYC cycles. Display data comes from an active shadow copy, which is
// refreshed from the pending copy only at a frame boundary.
// Ports:
//   clk, RESET        system clock, synchronous active-high reset
//   digit_in          packed nibbles, nibble i = digit i (digit 0 least significant)
//   dp_in, blank_in   per-digit decimal point / force-dark masks
//   hex_mode, lz_supp decode mode and leading-zero suppression
//   load              strobe capturing all of the above into the pending copy
//   SEG_COM           active-low digit commons (digit i on bit NUM_DIGITS-1-i)
//   SEG_DATA          {a,b,c,d,e,f,g,dp}, active-high
//   frame_done        one-cycle pulse after the last slot of a frame ends
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEAD_CYC   = 1
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [4*NUM_DIGITS-1:0]   digit_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      hex_mode,
    input  logic                      lz_supp,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     SEG_COM,
    output logic [7:0]                SEG_DATA,
    output logic                      frame_done
);

    localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DEAD_W = 4;
    localparam int unsigned DIG_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    typedef enum logic [0:0] {ST_SHOW, ST_DEAD} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [DEAD_W-1:0]   dead_cnt, dead_nxt;

    logic [DIG_W-1:0]      pend_digit, act_digit;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp;
    logic [NUM_DIGITS-1:0] pend_blank, act_blank;
    logic                  pend_hex, act_hex;
    logic                  pend_lz, act_lz;
    logic                  pend_valid;

    logic                  tick_c, wrap_c;
    logic [NUM_DIGITS-1:0] lz_dark_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_dp_c, cur_blank_c, cur_dark_c;
    logic [NUM_DIGITS-1:0] com_nxt;
    logic [7:0]            data_nxt;

    // Segment pattern {a..g}; in decimal mode 10-15 are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        if (!hex && (nib > 4'd9)) begin
            seg = 7'b0000000;
        end
        return seg;
    endfunction

    assign tick_c = (cnt == CNT_MAX);
    assign wrap_c = tick_c && (idx == IDX_MAX);

    // Leading-zero mask: a digit goes dark when it and every higher digit is zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_dark_c = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_digit[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_dark_c[i] = act_lz && zero_run;
            end
        end
    end

    // Active-register fields for the digit currently being scanned.
    always_comb begin
        cur_nib_c   = 4'h0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        cur_dark_c  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib_c   = act_digit[4*i +: 4];
                cur_dp_c    = act_dp[i];
                cur_blank_c = act_blank[i];
                cur_dark_c  = lz_dark_c[i];
            end
        end
    end

    // Slot FSM next state and the next values of the registered pin outputs.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dead_nxt  = dead_cnt;
        com_nxt   = '1;
        data_nxt  = 8'h00;

        if (tick_c) begin
            idx_nxt = wrap_c ? '0 : idx + IDX_W'(1);
            if (DEAD_CYC == 0) begin
                state_nxt = ST_SHOW;
            end else begin
                state_nxt = ST_DEAD;
                dead_nxt  = DEAD_LOAD;
            end
        end else if (state == ST_DEAD) begin
            if (dead_cnt == '0) begin
                state_nxt = ST_SHOW;
            end else begin
                dead_nxt = dead_cnt - DEAD_W'(1);
            end
        end

        if (state == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                com_nxt[i] = (idx != IDX_W'(NUM_DIGITS - 1 - i));
            end
            if (!cur_blank_c) begin
                data_nxt = {(cur_dark_c ? 7'b0000000 : seg_decode(cur_nib_c, act_hex)), cur_dp_c};
            end
        end
    end

    // State, divider, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= ST_SHOW;
            cnt        <= '0;
            idx        <= '0;
            dead_cnt   <= '0;
            pend_digit <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_hex   <= 1'b0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            act_digit  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_hex    <= 1'b0;
            act_lz     <= 1'b0;
            SEG_COM    <= '1;
            SEG_DATA   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            dead_cnt   <= dead_nxt;
            cnt        <= tick_c ? '0 : cnt + CNT_W'(1);
            SEG_COM    <= com_nxt;
            SEG_DATA   <= data_nxt;
            frame_done <= wrap_c;

            // Frame boundary consumes the old pending copy; a same-cycle load
            // refills pending and keeps pend_valid set for the next boundary.
            if (wrap_c && pend_valid) begin
                act_digit  <= pend_digit;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                act_hex    <= pend_hex;
                act_lz     <= pend_lz;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_digit <= digit_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_hex   <= hex_mode;
                pend_lz    <= lz_supp;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=6, SCAN_DIV=4, DEAD_CYC=1.
// Timeline after reset release (edge n = n-th rising edge): slot k ticks at edge 4(k+1);
// after edge 4m+1 (m>=1) the commons are dark, after edges 4m+2..4m+4 slot m is shown.
// Frame boundaries (and frame_done) fall on edges 24, 48, 72, ...
module tb_seg_scan_ctrl;

    logic        clk;
    logic        RESET;
    logic [23:0] digit_in;
    logic [5:0]  dp_in;
    logic [5:0]  blank_in;
    logic        hex_mode;
    logic        lz_supp;
    logic        load;
    logic [5:0]  SEG_COM;
    logic [7:0]  SEG_DATA;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (4),
        .DEAD_CYC   (1)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .digit_in   (digit_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .hex_mode   (hex_mode),
        .lz_supp    (lz_supp),
        .load       (load),
        .SEG_COM    (SEG_COM),
        .SEG_DATA   (SEG_DATA),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [5:0] com, input logic [7:0] data);
        chk({tag, "_com"}, 32'(SEG_COM), 32'(com));
        chk({tag, "_data"}, 32'(SEG_DATA), 32'(data));
    endtask

    // Advance to just after rising edge e (relative to the last reset release).
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Present a load so that it is sampled on edge e; inputs are scrambled afterwards.
    task automatic do_load(input int e, input logic [23:0] d, input logic [5:0] dp,
                           input logic [5:0] bl, input logic hx, input logic lz);
        goto(e - 1);
        digit_in = d;
        dp_in    = dp;
        blank_in = bl;
        hex_mode = hx;
        lz_supp  = lz;
        load     = 1'b1;
        goto(e);
        load     = 1'b0;
        digit_in = 24'hFFFFFF;
        dp_in    = 6'h3F;
        blank_in = 6'h3F;
    endtask

    initial begin
        RESET    = 1'b1;
        digit_in = '0;
        dp_in    = '0;
        blank_in = '0;
        hex_mode = 1'b0;
        lz_supp  = 1'b0;
        load     = 1'b0;

        // T1 reset
        repeat (3) @(posedge clk);
        #1;
        chk_slot("rst", 6'h3F, 8'h00);
        chk("rst_fd", 32'(frame_done), 32'd0);
        RESET = 1'b0;
        cyc   = 0;

        goto(1);
        chk_slot("post_rst_d0", 6'b011111, 8'hFC);

        // T2 scan order; old (reset) contents persist until the boundary
        do_load(2, 24'h543210, 6'h00, 6'h00, 1'b1, 1'b0);
        goto(22); chk_slot("f0_d5_old", 6'b111110, 8'hFC);
        goto(23); chk("fd_e23", 32'(frame_done), 32'd0);
        goto(24); chk("fd_e24", 32'(frame_done), 32'd1);
        goto(25); chk("fd_e25", 32'(frame_done), 32'd0);
                  chk_slot("dead_e25", 6'h3F, 8'h00);
        goto(26); chk_slot("scan_d0", 6'b011111, 8'hFC);
        goto(29); chk_slot("dead_e29", 6'h3F, 8'h00);
        goto(30); chk_slot("scan_d1", 6'b101111, 8'h60);
        goto(34); chk_slot("scan_d2", 6'b110111, 8'hDA);
        goto(38); chk_slot("scan_d3", 6'b111011, 8'hF2);
        goto(42); chk_slot("scan_d4", 6'b111101, 8'h66);
        goto(46); chk_slot("scan_d5", 6'b111110, 8'hB6);
        goto(47); chk("fd_e47", 32'(frame_done), 32'd0);
        goto(48); chk("fd_e48", 32'(frame_done), 32'd1);
        goto(49); chk("fd_e49", 32'(frame_done), 32'd0);

        // T3 hex vs decimal
        do_load(50, 24'h00000A, 6'h00, 6'h00, 1'b1, 1'b0);
        goto(74); chk_slot("hex_A", 6'b011111, 8'hEE);
        do_load(75, 24'h00000A, 6'h00, 6'h00, 1'b0, 1'b0);
        goto(98); chk_slot("dec_A_dark", 6'b011111, 8'h00);

        // T4 leading-zero suppression with a dp on a suppressed digit
        do_load(99, 24'h000070, 6'b000100, 6'h00, 1'b0, 1'b1);
        goto(102); chk_slot("dec_d1_zero", 6'b101111, 8'hFC);
        goto(122); chk_slot("lz_d0", 6'b011111, 8'hFC);
        goto(126); chk_slot("lz_d1", 6'b101111, 8'hE0);
        goto(130); chk_slot("lz_d2_dp", 6'b110111, 8'h01);
        goto(134); chk_slot("lz_d3", 6'b111011, 8'h00);
        goto(138); chk_slot("lz_d4", 6'b111101, 8'h00);
        goto(142); chk_slot("lz_d5", 6'b111110, 8'h00);

        // T5 atomicity: mid-frame load, load on the wrap edge, last load wins
        goto(154); chk_slot("atom_d2_old", 6'b110111, 8'h01);
        do_load(158, 24'h111111, 6'h00, 6'h00, 1'b0, 1'b0);
        goto(162); chk_slot("atom_d4_old", 6'b111101, 8'h00);
        goto(166); chk_slot("atom_d5_old", 6'b111110, 8'h00);
        goto(170); chk_slot("atom_d0_new", 6'b011111, 8'h60);
        goto(182); chk_slot("atom_d3_new", 6'b111011, 8'h60);
        do_load(192, 24'h222222, 6'h00, 6'h00, 1'b0, 1'b0);
        goto(194); chk_slot("wrapld_d0_old", 6'b011111, 8'h60);
        goto(214); chk_slot("wrapld_d5_old", 6'b111110, 8'h60);
        goto(218); chk_slot("wrapld_d0_new", 6'b011111, 8'hDA);
        do_load(220, 24'h333333, 6'h00, 6'h00, 1'b0, 1'b0);
        goto(222); chk_slot("multi_d1_old", 6'b101111, 8'hDA);
        do_load(224, 24'h444444, 6'b000011, 6'b000010, 1'b0, 1'b0);
        goto(242); chk_slot("last_wins_d0", 6'b011111, 8'h67);
        goto(246); chk_slot("blank_d1", 6'b101111, 8'h00);
        goto(250); chk_slot("last_wins_d2", 6'b110111, 8'h66);

        // T6 reset during the idx 4 slot
        goto(258); chk_slot("pre_rst_d4", 6'b111101, 8'h66);
        RESET = 1'b1;
        goto(259);
        RESET = 1'b0;
        chk_slot("mid_rst", 6'h3F, 8'h00);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        cyc = 0;
        for (int e = 1; e <= 23; e++) begin
            goto(e);
            chk("fd_quiet", 32'(frame_done), 32'd0);
            if (e == 1) chk_slot("rst2_d0", 6'b011111, 8'hFC);
            if (e == 6) chk_slot("rst2_d1", 6'b101111, 8'hFC);
        end
        goto(24); chk("rst2_fd_e24", 32'(frame_done), 32'd1);
        goto(25); chk("rst2_fd_e25", 32'(frame_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
